i2c_apb_sequencer: RTL and testbench
====================================

// Module: i2c_apb_sequencer
// PURPOSE
//  APB master that runs complete I2C transfers on the i2c master top, replacing hand-written CPU APB sequences.
//  Accepts one transfer request with byte streams; issues register writes (prescaler, cmd, address, tx data).
//  Polls status until the transfer finishes; for reads, drains RX bytes and reports completion and NACK.
// PARAMETERS
//  ADDR_PRESC     8'h00  prescaler register address
//  ADDR_CMD       8'h01  command register address
//  ADDR_TXDATA    8'h02  tx data register address
//  ADDR_STATUS    8'h03  status register address
//  ADDR_SLAVE     8'h04  slave address + rw register address
//  ADDR_RXDATA    8'h05  rx data register address
//  CMD_IDLE       8'h24  cmd value: core out of reset, not enabled
//  CMD_GO         8'h64  cmd value: core enabled, start transfer
//  STAT_DONE_BIT  0      status bit index: transfer complete
//  STAT_NACK_BIT  1      status bit index: slave NACK seen
//  POLL_TIMEOUT   255    max status polls before abort (only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  pclk_i          in   1  APB / sequencer clock
//  preset_n_i      in   1  async active-low reset
//  req_valid_i     in   1  transfer request valid
//  req_ready_o     out  1  sequencer idle, request accepted when valid&ready
//  req_rw_i        in   1  0 = write, 1 = read
//  req_addr_i      in   7  7-bit slave address
//  req_len_i       in   4  byte count, 0..15
//  req_presc_i     in   8  prescaler value
//  wr_valid_i      in   1  tx byte valid
//  wr_data_i       in   8  tx byte
//  wr_ready_o      out  1  tx byte consumed when valid&ready
//  rd_valid_o      out  1  rx byte valid (1-cycle pulse)
//  rd_data_o       out  8  rx byte
//  done_o          out  1  transfer finished (1-cycle pulse)
//  nack_o          out  1  qualifies done_o: slave NACK or timeout
//  psel_o/penable_o/pwrite_o out 1 APB master controls
//  paddr_o         out  8  APB address
//  pwdata_o        out  8  APB write data
//  prdata_i        in   8  APB read data
//  pready_i        in   1  APB ready
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready_o=1; FSM IDLE; latched request cleared.
//  APB: SETUP 1 cycle (psel=1,penable=0), ACCESS held until pready_i=1, then >=1 idle cycle
//   (psel=0) before next SETUP. paddr/pwdata/pwrite stable SETUP through ACCESS.
//  Request latched on req_valid_i&req_ready_o; req_ready_o low until cycle after done_o.
//  FSM: IDLE -> PRESC(wr presc) -> CMD_RST(wr CMD_IDLE) -> SLAVE(wr {addr,rw})
//   -> TXDATA (write only: per byte, wait wr_valid_i, wr_ready_o 1 cycle, wr ADDR_TXDATA; len times)
//   -> GO(wr CMD_GO) -> POLL(rd status; repeat until done bit=1)
//   -> RXDATA (read only, no NACK: rd ADDR_RXDATA len times, rd_valid_o pulse the cycle after pready)
//   -> STOP(wr CMD_IDLE) -> DONE(done_o=1, nack_o=status NACK bit) -> IDLE.
//  len=0: TXDATA/RXDATA skipped; address-only transfer still performed.
//  NACK seen at POLL: RXDATA skipped, STOP then DONE with nack_o=1.
//  TXDATA stalls indefinitely while wr_valid_i=0 (no APB activity); wr_valid_i ignored outside TXDATA.
//  Byte counter 4 bits, counts down, exits at 0; no wrap.
//  Reset mid-transfer: APB returns to idle asynchronously, no done_o; i2c core re-init is via next request.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined: 8-bit poll counter; when POLL_TIMEOUT polls done without done bit,
//   go STOP then DONE with nack_o=1. Undefined: POLL waits forever, counter not present.
// TESTING
//  Write addr=7'h10 len=2 bytes 55,51, presc=4 -> APB writes 00:04,01:24,04:20,02:55,02:51,01:64,
//   status polls, 01:24, done_o=1 nack_o=0.
//  Read addr=7'h10 len=2, status done, rx bytes A5,3C -> 04:21, rd_valid_o twice with A5 then 3C, done_o.
//  len=0 write -> no ADDR_TXDATA access, wr_ready_o never high, done_o after STOP.
//  Status returns NACK bit (8'h03) on read -> no ADDR_RXDATA read, rd_valid_o never high, nack_o=1.
//  pready_i held low 5 cycles in ACCESS -> penable/paddr/pwdata held stable, sequence resumes unchanged.
//  Reset asserted during TXDATA -> psel_o=0, req_ready_o=1 immediately, no done_o; next request runs from PRESC.

Source files
------------

// File: rtl/i2c_apb_sequencer.sv
// APB master that runs whole I2C transfers (prescaler, cmd, slave address, tx bytes, status polling, rx drain).
// Optional macro I2C_SEQ_TIMEOUT_EN adds a status-poll limit that aborts the transfer with nack_o=1.
module i2c_apb_sequencer #(
    parameter logic [7:0] ADDR_PRESC    = 8'h00,
    parameter logic [7:0] ADDR_CMD      = 8'h01,
    parameter logic [7:0] ADDR_TXDATA   = 8'h02,
    parameter logic [7:0] ADDR_STATUS   = 8'h03,
    parameter logic [7:0] ADDR_SLAVE    = 8'h04,
    parameter logic [7:0] ADDR_RXDATA   = 8'h05,
    parameter logic [7:0] CMD_IDLE      = 8'h24,
    parameter logic [7:0] CMD_GO        = 8'h64,
    parameter int         STAT_DONE_BIT = 0,
    parameter int         STAT_NACK_BIT = 1
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter int         POLL_TIMEOUT  = 255
`endif
) (
    input  logic       pclk_i,
    input  logic       preset_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [6:0] req_addr_i,
    input  logic [3:0] req_len_i,
    input  logic [7:0] req_presc_i,
    input  logic       wr_valid_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ready_o,
    output logic       rd_valid_o,
    output logic [7:0] rd_data_o,
    output logic       done_o,
    output logic       nack_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] paddr_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i,
    output logic [3:0] dbg_state_o
);

    // Handshakes: req and wr streams transfer on a cycle where valid and ready are both high at
    // the rising clock edge; valid must stay high with stable data until that cycle.

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PRESC   = 4'd1,
        S_CMD_RST = 4'd2,
        S_SLAVE   = 4'd3,
        S_TX_WAIT = 4'd4,
        S_TXDATA  = 4'd5,
        S_GO      = 4'd6,
        S_POLL    = 4'd7,
        S_RXDATA  = 4'd8,
        S_STOP    = 4'd9,
        S_DONE    = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        AP_IDLE   = 2'd0,
        AP_SETUP  = 2'd1,
        AP_ACCESS = 2'd2
    } apb_phase_t;

    state_t     state_q, state_d;
    apb_phase_t phase_q, phase_d;

    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;

    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] presc_q, presc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       nack_q, nack_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [7:0] poll_cnt_q, poll_cnt_d;
`endif

    // Register access requested by the current sequencer state.
    logic       acc_req;
    logic [7:0] acc_addr;
    logic [7:0] acc_data;
    logic       acc_write;
    logic       acc_done;

    always_comb begin
        acc_req   = 1'b1;
        acc_addr  = 8'h00;
        acc_data  = 8'h00;
        acc_write = 1'b1;
        unique case (state_q)
            S_PRESC:   begin acc_addr = ADDR_PRESC;  acc_data = presc_q;         end
            S_CMD_RST: begin acc_addr = ADDR_CMD;    acc_data = CMD_IDLE;        end
            S_SLAVE:   begin acc_addr = ADDR_SLAVE;  acc_data = {addr_q, rw_q};  end
            S_TXDATA:  begin acc_addr = ADDR_TXDATA; acc_data = tx_byte_q;       end
            S_GO:      begin acc_addr = ADDR_CMD;    acc_data = CMD_GO;          end
            S_POLL:    begin acc_addr = ADDR_STATUS; acc_write = 1'b0;           end
            S_RXDATA:  begin acc_addr = ADDR_RXDATA; acc_write = 1'b0;           end
            S_STOP:    begin acc_addr = ADDR_CMD;    acc_data = CMD_IDLE;        end
            default:   begin acc_req = 1'b0;         acc_write = 1'b0;           end
        endcase
    end

    assign acc_done = (phase_q == AP_ACCESS) && pready_i;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        tx_byte_d  = tx_byte_q;
        nack_d     = nack_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    rw_d    = req_rw_i;
                    addr_d  = req_addr_i;
                    presc_d = req_presc_i;
                    cnt_d   = req_len_i;
                    nack_d  = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    poll_cnt_d = 8'd0;
`endif
                    state_d = S_PRESC;
                end
            end
            S_PRESC: begin
                if (acc_done) state_d = S_CMD_RST;
            end
            S_CMD_RST: begin
                if (acc_done) state_d = S_SLAVE;
            end
            S_SLAVE: begin
                if (acc_done) state_d = (!rw_q && cnt_q != 4'd0) ? S_TX_WAIT : S_GO;
            end
            S_TX_WAIT: begin
                if (wr_valid_i) begin
                    tx_byte_d = wr_data_i;
                    state_d   = S_TXDATA;
                end
            end
            S_TXDATA: begin
                if (acc_done) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? S_GO : S_TX_WAIT;
                end
            end
            S_GO: begin
                if (acc_done) state_d = S_POLL;
            end
            S_POLL: begin
                if (acc_done) begin
                    if (prdata_i[STAT_DONE_BIT]) begin
                        nack_d  = prdata_i[STAT_NACK_BIT];
                        state_d = (prdata_i[STAT_NACK_BIT] || !rw_q || cnt_q == 4'd0)
                                  ? S_STOP : S_RXDATA;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (poll_cnt_q == 8'(POLL_TIMEOUT - 1)) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                    end
`endif
                end
            end
            S_RXDATA: begin
                if (acc_done) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = prdata_i;
                    cnt_d      = cnt_q - 4'd1;
                    state_d    = (cnt_q == 4'd1) ? S_STOP : S_RXDATA;
                end
            end
            S_STOP: begin
                if (acc_done) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every access ends with psel low for a cycle because the next state only sees AP_IDLE then.
        if (acc_req) begin
            unique case (phase_q)
                AP_IDLE: begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = acc_addr;
                    pwdata_d  = acc_data;
                    pwrite_d  = acc_write;
                    phase_d   = AP_SETUP;
                end
                AP_SETUP: begin
                    penable_d = 1'b1;
                    phase_d   = AP_ACCESS;
                end
                AP_ACCESS: begin
                    if (pready_i) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        phase_d   = AP_IDLE;
                    end
                end
                default: begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    phase_d   = AP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q    <= S_IDLE;
            phase_q    <= AP_IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 8'h00;
            pwdata_q   <= 8'h00;
            rw_q       <= 1'b0;
            addr_q     <= 7'h00;
            presc_q    <= 8'h00;
            cnt_q      <= 4'd0;
            tx_byte_q  <= 8'h00;
            nack_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            tx_byte_q  <= tx_byte_d;
            nack_q     <= nack_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_TX_WAIT) && wr_valid_i;
    assign done_o      = (state_q == S_DONE);
    assign nack_o      = (state_q == S_DONE) && nack_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Self-checking bench for i2c_apb_sequencer: APB slave model, tx byte driver and a transfer-level reference model.
module tb_i2c_apb_sequencer;

    logic       pclk_i;
    logic       preset_n_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_rw_i;
    logic [6:0] req_addr_i;
    logic [3:0] req_len_i;
    logic [7:0] req_presc_i;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       done_o;
    logic       nack_o;
    logic       psel_o;
    logic       penable_o;
    logic       pwrite_o;
    logic [7:0] paddr_o;
    logic [7:0] pwdata_o;
    logic [7:0] prdata_i;
    logic       pready_i;
    logic [3:0] dbg_state_o;

    i2c_apb_sequencer dut (
        .pclk_i      (pclk_i),
        .preset_n_i  (preset_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_rw_i    (req_rw_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .req_presc_i (req_presc_i),
        .wr_valid_i  (wr_valid_i),
        .wr_data_i   (wr_data_i),
        .wr_ready_o  (wr_ready_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .done_o      (done_o),
        .nack_o      (nack_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    // ---------------- shared bench state ----------------
    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];      // {pwrite, paddr, data}
    logic [16:0] obs_q[$];
    logic [7:0]  tx_src_q[$];
    logic [7:0]  rx_src_q[$];
    logic [7:0]  status_src_q[$];
    logic [7:0]  rd_obs_q[$];

    int   wait_max   = 0;
    bit   wait_fixed = 1'b0;
    bit   junk_wr    = 1'b0;
    int   proto_err  = 0;
    int   done_cnt   = 0;
    logic nack_seen  = 1'b0;
    int   wr_hs_cnt  = 0;
    int   wr_ready_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    logic       prev_psel = 1'b0;
    logic [7:0] cap_addr;
    logic [7:0] cap_data;
    logic       cap_write;
    int         wcnt = 0;
    int         wtarget = 0;

    initial begin
        pready_i = 1'b0;
        prdata_i = 8'h00;
        forever begin
            logic [7:0] rv;
            @(posedge pclk_i);
            #1;
            if (!preset_n_i) begin
                pready_i  = 1'b0;
                wcnt      = 0;
                prev_psel = 1'b0;
            end else begin
                if (psel_o && !penable_o) begin
                    if (prev_psel) proto_err++;
                    cap_addr  = paddr_o;
                    cap_data  = pwdata_o;
                    cap_write = pwrite_o;
                    wcnt      = 0;
                    wtarget   = wait_fixed ? wait_max : $urandom_range(0, wait_max);
                    pready_i  = 1'b0;
                end else if (psel_o && penable_o) begin
                    if (paddr_o !== cap_addr || pwrite_o !== cap_write ||
                        (cap_write && pwdata_o !== cap_data)) proto_err++;
                    if (pready_i) begin
                        proto_err++;
                        pready_i = 1'b0;
                    end else if (wcnt == wtarget) begin
                        rv = 8'h00;
                        if (!pwrite_o && paddr_o == 8'h03)
                            rv = (status_src_q.size() > 0) ? status_src_q.pop_front() : 8'h00;
                        else if (!pwrite_o && paddr_o == 8'h05)
                            rv = (rx_src_q.size() > 0) ? rx_src_q.pop_front() : 8'hEE;
                        prdata_i = rv;
                        pready_i = 1'b1;
                        obs_q.push_back({pwrite_o, paddr_o, pwrite_o ? pwdata_o : rv});
                    end else begin
                        wcnt++;
                    end
                end else begin
                    if (penable_o) proto_err++;
                    pready_i = 1'b0;
                end
                prev_psel = psel_o;
            end
        end
    end

    // ---------------- tx byte driver ----------------
    initial begin
        wr_valid_i = 1'b0;
        wr_data_i  = 8'h00;
        forever begin
            bit hs;
            @(negedge pclk_i);
            hs = wr_valid_i && wr_ready_o && preset_n_i;
            @(posedge pclk_i);
            #1;
            if (hs) begin
                if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
                wr_hs_cnt++;
                wr_valid_i = 1'b0;
            end
            if (junk_wr) begin
                wr_valid_i = 1'b1;
                wr_data_i  = 8'($urandom);
            end else if (!wr_valid_i && tx_src_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                wr_valid_i = 1'b1;
                wr_data_i  = tx_src_q[0];
            end else if (tx_src_q.size() == 0) begin
                wr_valid_i = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge pclk_i) begin
        if (preset_n_i) begin
            if (rd_valid_o) rd_obs_q.push_back(rd_data_o);
            if (done_o) begin
                done_cnt++;
                nack_seen = nack_o;
            end
            if (wr_ready_o) wr_ready_cnt++;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- transfer task with reference model ----------------
    // Caller fills tx_src_q (write) or rx_src_q (read) with exactly len bytes.
    task automatic run_xfer(input logic rw, input logic [6:0] addr, input logic [3:0] len,
                            input logic [7:0] presc, input int n_polls, input logic nack_bit,
                            input string tag);
        logic [7:0] exp_rd[$];
        logic [7:0] fin;
        logic [16:0] ov;
        int cyc;
        exp_q.delete();
        obs_q.delete();
        rd_obs_q.delete();
        status_src_q.delete();
        done_cnt     = 0;
        nack_seen    = 1'b0;
        wr_hs_cnt    = 0;
        wr_ready_cnt = 0;
        proto_err    = 0;

        for (int i = 0; i < n_polls; i++) status_src_q.push_back({6'($urandom), 2'b00});
        fin = {6'($urandom), nack_bit, 1'b1};
        status_src_q.push_back(fin);

        exp_q.push_back({1'b1, 8'h00, presc});
        exp_q.push_back({1'b1, 8'h01, 8'h24});
        exp_q.push_back({1'b1, 8'h04, addr, rw});
        if (!rw) foreach (tx_src_q[i]) exp_q.push_back({1'b1, 8'h02, tx_src_q[i]});
        exp_q.push_back({1'b1, 8'h01, 8'h64});
        foreach (status_src_q[i]) exp_q.push_back({1'b0, 8'h03, status_src_q[i]});
        if (rw && !nack_bit) begin
            foreach (rx_src_q[i]) begin
                exp_q.push_back({1'b0, 8'h05, rx_src_q[i]});
                exp_rd.push_back(rx_src_q[i]);
            end
        end
        exp_q.push_back({1'b1, 8'h01, 8'h24});

        cyc = 0;
        while (!req_ready_o && cyc < 100) begin
            @(posedge pclk_i); #1;
            cyc++;
        end
        check({tag, ".req_ready_before"}, req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_rw_i    = rw;
        req_addr_i  = addr;
        req_len_i   = len;
        req_presc_i = presc;
        @(posedge pclk_i); #1;
        req_valid_i = 1'b0;
        req_rw_i    = 1'($urandom);
        req_addr_i  = 7'($urandom);
        req_len_i   = 4'($urandom);
        req_presc_i = 8'($urandom);
        check({tag, ".req_ready_busy"}, req_ready_o, 1'b0);

        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge pclk_i); #1;
            cyc++;
        end
        repeat (3) @(posedge pclk_i);
        #1;

        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".nack"}, nack_seen, nack_bit);
        check({tag, ".apb_count"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ov = (i < obs_q.size()) ? obs_q[i] : 17'h1ffff;
            check($sformatf("%s.apb[%0d]", tag, i), ov, exp_q[i]);
        end
        check({tag, ".rd_count"}, rd_obs_q.size(), exp_rd.size());
        foreach (exp_rd[i])
            check($sformatf("%s.rd[%0d]", tag, i),
                  (i < rd_obs_q.size()) ? rd_obs_q[i] : 8'hxx, exp_rd[i]);
        check({tag, ".wr_handshakes"}, wr_hs_cnt, rw ? 0 : int'(len));
        check({tag, ".wr_ready_cycles"}, wr_ready_cnt, rw ? 0 : int'(len));
        check({tag, ".tx_left"}, tx_src_q.size(), 0);
        check({tag, ".apb_protocol"}, proto_err, 0);
        check({tag, ".req_ready_after"}, req_ready_o, 1'b1);
        rx_src_q.delete();
        tx_src_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cyc;
        logic       r_rw;
        logic [3:0] r_len;
        preset_n_i  = 1'b0;
        req_valid_i = 1'b0;
        req_rw_i    = 1'b0;
        req_addr_i  = 7'h00;
        req_len_i   = 4'd0;
        req_presc_i = 8'h00;

        // reset values
        repeat (3) @(posedge pclk_i);
        #1;
        check("rst.req_ready", req_ready_o, 1'b1);
        check("rst.psel", psel_o, 1'b0);
        check("rst.penable", penable_o, 1'b0);
        check("rst.pwrite", pwrite_o, 1'b0);
        check("rst.paddr", paddr_o, 8'h00);
        check("rst.pwdata", pwdata_o, 8'h00);
        check("rst.done", done_o, 1'b0);
        check("rst.nack", nack_o, 1'b0);
        check("rst.rd_valid", rd_valid_o, 1'b0);
        check("rst.wr_ready", wr_ready_o, 1'b0);
        check("rst.dbg_state", dbg_state_o, 4'd0);
        @(negedge pclk_i);
        preset_n_i = 1'b1;
        repeat (2) @(posedge pclk_i);
        #1;
        check("post_rst.psel", psel_o, 1'b0);

        // write addr 10, bytes 55 51, presc 4
        tx_src_q = '{8'h55, 8'h51};
        run_xfer(1'b0, 7'h10, 4'd2, 8'h04, 2, 1'b0, "wr_basic");

        // read addr 10, rx A5 3C
        rx_src_q = '{8'hA5, 8'h3C};
        run_xfer(1'b1, 7'h10, 4'd2, 8'h04, 1, 1'b0, "rd_basic");

        // len=0 write while wr_valid_i is held high with junk
        junk_wr = 1'b1;
        run_xfer(1'b0, 7'h2A, 4'd0, 8'h10, 0, 1'b0, "wr_len0");

        // NACK on a read: no rx draining
        rx_src_q = '{8'h11, 8'h22, 8'h33};
        run_xfer(1'b1, 7'h50, 4'd3, 8'h08, 2, 1'b1, "rd_nack");
        junk_wr = 1'b0;

        // len=0 read
        run_xfer(1'b1, 7'h33, 4'd0, 8'h01, 0, 1'b0, "rd_len0");

        // 5 wait states on every access
        wait_fixed = 1'b1;
        wait_max   = 5;
        tx_src_q = '{8'hC3};
        run_xfer(1'b0, 7'h7F, 4'd1, 8'hFF, 1, 1'b0, "wr_wait5");
        rx_src_q = '{8'h96};
        run_xfer(1'b1, 7'h01, 4'd1, 8'h02, 0, 1'b0, "rd_wait5");

        // reset while a TXDATA access is in progress
        tx_src_q  = '{8'h77};
        done_cnt  = 0;
        obs_q.delete();
        req_valid_i = 1'b1;
        req_rw_i    = 1'b0;
        req_addr_i  = 7'h22;
        req_len_i   = 4'd3;
        req_presc_i = 8'h09;
        @(posedge pclk_i); #1;
        req_valid_i = 1'b0;
        cyc = 0;
        while (!(psel_o && paddr_o == 8'h02) && cyc < 300) begin
            @(posedge pclk_i); #1;
            cyc++;
        end
        check("rst_mid.reached_txdata", {psel_o, paddr_o}, {1'b1, 8'h02});
        #2;
        preset_n_i = 1'b0;
        #1;
        check("rst_mid.psel", psel_o, 1'b0);
        check("rst_mid.penable", penable_o, 1'b0);
        check("rst_mid.req_ready", req_ready_o, 1'b1);
        repeat (3) @(posedge pclk_i);
        #1;
        check("rst_mid.no_done", done_cnt, 0);
        @(negedge pclk_i);
        preset_n_i = 1'b1;
        wait_fixed = 1'b0;
        wait_max   = 2;
        tx_src_q.delete();
        repeat (2) @(posedge pclk_i);
        #1;
        check("rst_mid.idle_psel", psel_o, 1'b0);
        tx_src_q = '{8'h0F, 8'hF0, 8'h5A};
        run_xfer(1'b0, 7'h22, 4'd3, 8'h09, 1, 1'b0, "after_rst");

        // randomized transfers
        for (int t = 0; t < 10; t++) begin
            r_rw     = 1'($urandom_range(0, 1));
            r_len    = (t == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            wait_max = $urandom_range(0, 3);
            for (int b = 0; b < int'(r_len); b++) begin
                if (r_rw) rx_src_q.push_back(8'($urandom));
                else      tx_src_q.push_back(8'($urandom));
            end
            run_xfer(r_rw, 7'($urandom), r_len, 8'($urandom), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
